// File: rtl/uart_rx_frontend.sv
// ============================================================================
//  Module   : uart_rx_frontend
//  Purpose  : Oversampling 8N1 UART receiver front end. It synchronises the
//             asynchronous rx line, detects the start edge, samples each bit
//             near its centre and emits one byte per good frame. Stop-bit
//             failures are reported as framing errors.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous, active-high reset
//             rx         - asynchronous serial line, idles high
//             data_out   - last correctly received byte (holds between strobes)
//             valid      - one-cycle strobe when data_out is updated
//             frame_err  - one-cycle strobe when the stop bit is sampled low
//             busy       - high while a frame is in progress
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_half    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] c_full_m1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_live;
    logic                   r_rx_prev;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shreg;

    logic w_rx_s;
    logic w_fall;
    logic w_toggle;

    assign w_rx_s   = r_sync[SYNC_STAGES-1];
    // r_live fills with ones behind the synchroniser so that r_rx_prev is
    // known to hold a real line sample rather than its reset value. Without
    // it a line held low out of reset would look like a start edge.
    assign w_fall   = r_live[SYNC_STAGES] & r_rx_prev & ~w_rx_s;
    assign w_toggle = w_rx_s ^ r_rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sync    <= '1;
            r_live    <= '0;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_live    <= {r_live[SYNC_STAGES-1:0], 1'b1};
            r_rx_prev <= w_rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            // Busy reflects the state of the previous cycle, so it is still
            // high while valid is asserted and drops on the following cycle.
            busy      <= (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (r_cnt == c_half_m1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (r_cnt == c_full_m1) begin
                        r_shreg[r_bit_idx] <= w_rx_s;
                        r_cnt              <= '0;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else if (w_toggle) begin
                        // Re-centre on every bit boundary. At the nominal rate
                        // this loads the value the counter would reach anyway;
                        // with a slow or fast sender it stops the sample point
                        // drifting out of the bit over the frame.
                        r_cnt <= c_half;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (r_cnt == c_full_m1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            data_out <= r_shreg;
                            valid    <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= ST_BREAK;
                        end
                    end else if (w_toggle) begin
                        r_cnt <= c_half;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    // Only a return to idle-high re-arms edge detection, so a
                    // long low line produces a single framing error.
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
//  Module   : tb_uart_rx_frontend
//  Purpose  : Self-checking bench for uart_rx_frontend. A serial line driver
//             pushes the expected outcome of every frame into a queue; a
//             monitor pops and compares whenever valid or frame_err fires.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frontend;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_frontend #(
        .CLKS_PER_BIT (16),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         t_last_valid = 0;
    int         t_start = 0;
    logic [7:0] model_last = 8'h00;
    logic [7:0] mon_data = 8'h00;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drive one 8N1 frame LSB first; the stop level is chosen by the caller.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_lvl);
        rx = 1'b0;
        t_start = cyc;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b, input int cpb);
        q.push_back('{is_err: 1'b0, data: b});
        model_last = b;
        send_frame(b, cpb, 1'b1);
    endtask

    // Leaves rx low after the bad stop bit; the caller decides when to release.
    task automatic send_bad(input logic [7:0] b, input int cpb);
        q.push_back('{is_err: 1'b1, data: model_last});
        send_frame(b, cpb, 1'b0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            mon_data   = 8'h00;
            prev_valid = 1'b0;
        end else begin
            exp_t e;
            if (valid && frame_err) begin
                checks++; errors++;
                $display("FAIL valid_and_err: got both high expected exclusive");
            end
            if (prev_valid) check("busy_after_valid", busy, 0);
            if (valid) begin
                n_valid++;
                t_last_valid = cyc;
                check("busy_during_valid", busy, 1);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got data %0h expected no output", data_out);
                end else begin
                    e = q.pop_front();
                    check("valid_kind", e.is_err, 0);
                    check("valid_data", data_out, e.data);
                    mon_data = e.data;
                end
            end else if (frame_err) begin
                n_err++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: got frame_err expected no output");
                end else begin
                    e = q.pop_front();
                    check("err_kind", e.is_err, 1);
                    check("err_data_hold", data_out, e.data);
                end
            end else begin
                check("data_hold", data_out, mon_data);
            end
            prev_valid = valid;
        end
    end

    initial begin
        int nv, ne, t1, t2;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data_out, 8'h00);
        check("reset_valid", valid, 0);
        check("reset_err", frame_err, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Single frame with latency window.
        nv = n_valid; ne = n_err;
        send_good(8'hCC, 16);
        check_range("cc_latency", t_last_valid - t_start, 152, 156);
        repeat (16) @(negedge clk);
        check("cc_valid_cnt", n_valid - nv, 1);
        check("cc_err_cnt", n_err - ne, 0);
        check("cc_busy_idle", busy, 0);
        check("cc_data", data_out, 8'hCC);

        // Back-to-back frames, no idle gap.
        nv = n_valid;
        send_good(8'h55, 16);
        t1 = t_last_valid;
        send_good(8'hA3, 16);
        t2 = t_last_valid;
        repeat (16) @(negedge clk);
        check("b2b_valid_cnt", n_valid - nv, 2);
        check_range("b2b_spacing", t2 - t1, 159, 161);
        check("b2b_data", data_out, 8'hA3);

        // Short glitch is a false start.
        nv = n_valid; ne = n_err;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (8) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        check("glitch_valid_cnt", n_valid - nv, 0);
        check("glitch_err_cnt", n_err - ne, 0);
        repeat (10) @(negedge clk);
        send_good(8'h3C, 16);
        repeat (16) @(negedge clk);
        check("glitch_next_data", data_out, 8'h3C);

        // Framing error followed by a long low line.
        nv = n_valid; ne = n_err;
        send_bad(8'h0F, 16);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_err_cnt", n_err - ne, 1);
        check("ferr_valid_cnt", n_valid - nv, 0);
        check("ferr_data_kept", data_out, 8'h3C);
        send_good(8'h81, 16);
        repeat (16) @(negedge clk);
        check("ferr_next_data", data_out, 8'h81);

        // Reset during data bit 4 of 0xF0.
        nv = n_valid; ne = n_err;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        model_last = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (8 + 3 * 16 + 16 + 20) @(negedge clk);
        check("rst_valid_cnt", n_valid - nv, 0);
        check("rst_err_cnt", n_err - ne, 0);
        check("rst_data", data_out, 8'h00);
        check("rst_busy", busy, 0);
        send_good(8'h7E, 16);
        repeat (16) @(negedge clk);
        check("rst_next_data", data_out, 8'h7E);

        // Rate tolerance.
        nv = n_valid;
        send_good(8'h96, 15);
        repeat (32) @(negedge clk);
        check("rate15_data", data_out, 8'h96);
        check("rate15_valid_cnt", n_valid - nv, 1);
        nv = n_valid;
        send_good(8'h96, 17);
        repeat (32) @(negedge clk);
        check("rate17_data", data_out, 8'h96);
        check("rate17_valid_cnt", n_valid - nv, 1);

        // Random bytes, random gaps, occasional bad stop bit.
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
                send_bad(b, 16);
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rx = 1'b1;
                repeat ($urandom_range(4, 20)) @(negedge clk);
            end else begin
                send_good(b, 16);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end

        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        check("drain_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
